// File: rtl/sde_ps_wr_seq_pkg.sv
// Shared constants and types for the PCIS write-burst sequencer.
//   BEAT_BYTES / BEAT_SHIFT : bytes per data beat and its log2
//   LEN_W / RESP_W          : AXI len and resp field widths
//   RESP_OKAY / RESP_SLVERR : B response codes
//   state_e                 : sequencer FSM states
//   sat_inc                 : saturating beat-counter increment
package sde_ps_wr_seq_pkg;

  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned RESP_W     = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Beat counter sticks at all-ones so overlong bursts cannot wrap it.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + LEN_W'(1);
  endfunction

endpackage

// File: rtl/sde_ps_wr_seq_if.sv
// PCIS write-channel bundle between the host side and the write sequencer.
//   AW : pcis_awid, pcis_awaddr, pcis_awlen, pcis_awvalid, pcis_awready
//   W  : pcis_wvalid, pcis_wready, pcis_wlast (snooped only)
//   B  : pcis_bid, pcis_bresp, pcis_bvalid, pcis_bready
//   accumulator control : pcis_req_wr, pcis_req_addr
// slave modport = sequencer view, master modport = host/accumulator view.
interface sde_ps_wr_seq_if #(
  parameter int unsigned PCIS_ADDR_WIDTH = 64,
  parameter int unsigned PCIS_ID_WIDTH   = 16
) ();
  import sde_ps_wr_seq_pkg::*;

  logic [PCIS_ID_WIDTH-1:0]   pcis_awid;
  logic [PCIS_ADDR_WIDTH-1:0] pcis_awaddr;
  logic [LEN_W-1:0]           pcis_awlen;
  logic                       pcis_awvalid;
  logic                       pcis_awready;

  logic                       pcis_wvalid;
  logic                       pcis_wready;
  logic                       pcis_wlast;

  logic [PCIS_ID_WIDTH-1:0]   pcis_bid;
  logic [RESP_W-1:0]          pcis_bresp;
  logic                       pcis_bvalid;
  logic                       pcis_bready;

  logic                       pcis_req_wr;
  logic [PCIS_ADDR_WIDTH-1:0] pcis_req_addr;

  modport slave (
    input  pcis_awid, pcis_awaddr, pcis_awlen, pcis_awvalid,
    input  pcis_wvalid, pcis_wready, pcis_wlast,
    input  pcis_bready,
    output pcis_awready, pcis_bid, pcis_bresp, pcis_bvalid,
    output pcis_req_wr, pcis_req_addr
  );

  modport master (
    output pcis_awid, pcis_awaddr, pcis_awlen, pcis_awvalid,
    output pcis_wvalid, pcis_wready, pcis_wlast,
    output pcis_bready,
    input  pcis_awready, pcis_bid, pcis_bresp, pcis_bvalid,
    input  pcis_req_wr, pcis_req_addr
  );

endinterface

// File: rtl/sde_aw_fifo.sv
// Synchronous FIFO for queued write-address entries.
//   clk, rst_n      : clock, async active-low reset
//   i_push, i_data  : write request / entry (ignored while o_ready is low)
//   i_pop           : read request (ignored while empty)
//   o_data          : head entry
//   o_empty         : registered empty flag
//   o_ready         : registered not-full flag, low during reset
//   o_empty_nxt_c   : combinational empty flag for the next cycle
module sde_aw_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_ready,
  output logic             o_empty_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_empty;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & r_ready;
  assign w_pop  = i_pop & ~r_empty;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Pointers and flags; ready resets low so nothing is accepted during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_ready <= (w_count_nxt != CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data        = r_mem[r_rd_ptr];
  assign o_empty       = r_empty;
  assign o_ready       = r_ready;
  assign o_empty_nxt_c = (w_count_nxt == '0);

endmodule

// File: rtl/sde_ps_wr_seq.sv
// PCIS write-burst sequencer: queues AW requests, steers the data
// accumulator one burst at a time with per-beat addresses, checks burst
// length against wlast and issues one B response per burst.
//   clk, rst_n   : clock, async active-low reset
//   bus          : AW / W-snoop / B / accumulator-control bundle (slave)
//   ooo_error    : accumulator out-of-order error pulse
//   unalin_error : accumulator unaligned error pulse
//   len_error    : one-cycle pulse on a burst length violation
//   busy         : burst in progress or AW queue non-empty
module sde_ps_wr_seq
  import sde_ps_wr_seq_pkg::*;
#(
  parameter int unsigned PCIS_ADDR_WIDTH = 64,
  parameter int unsigned PCIS_ID_WIDTH   = 16,
  parameter int unsigned AW_FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  sde_ps_wr_seq_if.slave bus,
  input  logic          ooo_error,
  input  logic          unalin_error,
  output logic          len_error,
  output logic          busy
);

  localparam int unsigned ENTRY_W = PCIS_ID_WIDTH + PCIS_ADDR_WIDTH + LEN_W;

  state_e                      r_state;
  state_e                      w_state_nxt;

  logic [ENTRY_W-1:0]          w_fifo_din;
  logic [ENTRY_W-1:0]          w_fifo_dout;
  logic                        w_fifo_empty;
  logic                        w_fifo_empty_nxt;
  logic                        w_fifo_ready;
  logic                        w_pop;

  logic [PCIS_ID_WIDTH-1:0]    w_head_id;
  logic [PCIS_ADDR_WIDTH-1:0]  w_head_addr;
  logic [LEN_W-1:0]            w_head_len;

  logic [PCIS_ID_WIDTH-1:0]    r_id;
  logic [PCIS_ADDR_WIDTH-1:0]  r_base;
  logic [LEN_W-1:0]            r_len;
  logic [LEN_W-1:0]            r_beat_cnt;
  logic [LEN_W-1:0]            w_cnt_nxt;
  logic                        r_err;

  logic                        r_req_wr;
  logic [PCIS_ADDR_WIDTH-1:0]  r_req_addr;
  logic                        r_bvalid;
  logic [PCIS_ID_WIDTH-1:0]    r_bid;
  logic [RESP_W-1:0]           r_bresp;
  logic                        r_len_error;
  logic                        r_busy;

  logic                        w_beat;
  logic                        w_len_bad;
  logic                        w_acc_err;

  // AW queue; acceptance is independent of the FSM.
  assign w_fifo_din = {bus.pcis_awid, bus.pcis_awaddr, bus.pcis_awlen};
  assign w_pop      = (r_state == ST_IDLE) & ~w_fifo_empty;

  sde_aw_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (AW_FIFO_DEPTH)
  ) u_aw_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (bus.pcis_awvalid),
    .i_data        (w_fifo_din),
    .i_pop         (w_pop),
    .o_data        (w_fifo_dout),
    .o_empty       (w_fifo_empty),
    .o_ready       (w_fifo_ready),
    .o_empty_nxt_c (w_fifo_empty_nxt)
  );

  assign w_head_id   = w_fifo_dout[ENTRY_W-1 -: PCIS_ID_WIDTH];
  assign w_head_addr = w_fifo_dout[LEN_W +: PCIS_ADDR_WIDTH];
  assign w_head_len  = w_fifo_dout[0 +: LEN_W];

  // A beat only counts while the accumulator is being driven.
  assign w_beat    = bus.pcis_wvalid & bus.pcis_wready & r_req_wr;
  assign w_len_bad = w_beat & (bus.pcis_wlast ? (r_beat_cnt != r_len)
                                              : (r_beat_cnt >= r_len));
  assign w_acc_err = ooo_error | unalin_error;
  assign w_cnt_nxt = sat_inc(r_beat_cnt);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a burst only ends on wlast.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!w_fifo_empty) w_state_nxt = ST_DATA;
      ST_DATA:  if (w_beat && bus.pcis_wlast) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_RESP;
      ST_RESP:  if (bus.pcis_bready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Burst context, accumulator control and B channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id        <= '0;
      r_base      <= '0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
      r_req_wr    <= 1'b0;
      r_req_addr  <= '0;
      r_bvalid    <= 1'b0;
      r_bid       <= '0;
      r_bresp     <= '0;
      r_len_error <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_len_error <= w_len_bad;
      r_busy      <= (w_state_nxt != ST_IDLE) | ~w_fifo_empty_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_id       <= w_head_id;
            r_base     <= w_head_addr;
            r_len      <= w_head_len;
            r_req_addr <= w_head_addr;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_req_wr   <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_beat) begin
            r_beat_cnt <= w_cnt_nxt;
            r_req_addr <= r_base + (PCIS_ADDR_WIDTH'(w_cnt_nxt) << BEAT_SHIFT);
            if (bus.pcis_wlast) r_req_wr <= 1'b0;
          end
          if (w_len_bad || w_acc_err) r_err <= 1'b1;
        end
        // Late accumulator errors arriving in DRAIN still taint the response.
        ST_DRAIN: begin
          r_bvalid <= 1'b1;
          r_bid    <= r_id;
          r_bresp  <= (r_err || w_acc_err) ? RESP_SLVERR : RESP_OKAY;
        end
        ST_RESP: begin
          if (bus.pcis_bready) r_bvalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.pcis_awready  = w_fifo_ready;
  assign bus.pcis_req_wr   = r_req_wr;
  assign bus.pcis_req_addr = r_req_addr;
  assign bus.pcis_bvalid   = r_bvalid;
  assign bus.pcis_bid      = r_bid;
  assign bus.pcis_bresp    = r_bresp;
  assign len_error         = r_len_error;
  assign busy              = r_busy;

endmodule

// File: tb/tb_sde_ps_wr_seq.sv
// Scoreboard bench for sde_ps_wr_seq: directed bursts push expected B
// responses and beat addresses; a negedge monitor pops and compares.
module tb_sde_ps_wr_seq;
  import sde_ps_wr_seq_pkg::*;

  localparam int unsigned AW_W = 64;
  localparam int unsigned ID_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ooo_error;
  logic unalin_error;
  logic len_error;
  logic busy;

  sde_ps_wr_seq_if #(.PCIS_ADDR_WIDTH(AW_W), .PCIS_ID_WIDTH(ID_W)) bus ();

  sde_ps_wr_seq #(
    .PCIS_ADDR_WIDTH (AW_W),
    .PCIS_ID_WIDTH   (ID_W),
    .AW_FIFO_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ooo_error    (ooo_error),
    .unalin_error (unalin_error),
    .len_error    (len_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [RESP_W-1:0] resp;
  } b_exp_t;

  int          total = 0;
  int          bad = 0;
  int          len_err_seen = 0;
  int          len_err_exp = 0;
  b_exp_t      q_b[$];
  logic [63:0] q_addr[$];
  b_exp_t      mon_b;
  logic [63:0] mon_a;

  function automatic b_exp_t mk_b(input logic [ID_W-1:0] id, input logic [RESP_W-1:0] resp);
    b_exp_t r;
    r.id = id;
    r.resp = resp;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: B handshakes, accumulator beats and len_error pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pcis_bvalid && bus.pcis_bready) begin
        if (q_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected: got bid=%0h want no response", bus.pcis_bid);
        end else begin
          mon_b = q_b.pop_front();
          check("bid", 64'(bus.pcis_bid), 64'(mon_b.id));
          check("bresp", 64'(bus.pcis_bresp), 64'(mon_b.resp));
        end
      end
      if (bus.pcis_wvalid && bus.pcis_wready && bus.pcis_req_wr) begin
        if (q_addr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got addr=%0h want no beat", bus.pcis_req_addr);
        end else begin
          mon_a = q_addr.pop_front();
          check("req_addr", bus.pcis_req_addr, mon_a);
        end
      end
      if (len_error) len_err_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [ID_W-1:0] id, input logic [63:0] addr, input logic [7:0] len);
    int n = 0;
    bit acc = 1'b0;
    bus.pcis_awid    = id;
    bus.pcis_awaddr  = addr;
    bus.pcis_awlen   = len;
    bus.pcis_awvalid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.pcis_awready;
      tick();
      n++;
    end
    bus.pcis_awvalid = 1'b0;
    check("aw_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_req_wr();
    int n = 0;
    while (!bus.pcis_req_wr && n < 100) begin
      tick();
      n++;
    end
    check("req_wr_wait", 64'(bus.pcis_req_wr), 64'd1);
  endtask

  task automatic w_beats(input logic [63:0] base, input int nb, input bit last);
    wait_req_wr();
    for (int k = 0; k < nb; k++) begin
      q_addr.push_back(base + 64'(k) * 64'd64);
      bus.pcis_wvalid = 1'b1;
      bus.pcis_wready = 1'b1;
      bus.pcis_wlast  = last && (k == nb - 1);
      tick();
    end
    bus.pcis_wvalid = 1'b0;
    bus.pcis_wready = 1'b0;
    bus.pcis_wlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_b.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check("drain_q_b", 64'(q_b.size()), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_awready"}, 64'(bus.pcis_awready), 64'd0);
    check({tag, "_req_wr"}, 64'(bus.pcis_req_wr), 64'd0);
    check({tag, "_req_addr"}, bus.pcis_req_addr, 64'd0);
    check({tag, "_bvalid"}, 64'(bus.pcis_bvalid), 64'd0);
    check({tag, "_bid"}, 64'(bus.pcis_bid), 64'd0);
    check({tag, "_bresp"}, 64'(bus.pcis_bresp), 64'd0);
    check({tag, "_len_error"}, 64'(len_error), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pcis_awid = '0; bus.pcis_awaddr = '0; bus.pcis_awlen = '0; bus.pcis_awvalid = 1'b0;
    bus.pcis_wvalid = 1'b0; bus.pcis_wready = 1'b0; bus.pcis_wlast = 1'b0;
    bus.pcis_bready = 1'b0;
    ooo_error = 1'b0;
    unalin_error = 1'b0;
    rst_n = 1'b0;

    // Reset values, then awready rises on the first edge after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("awready_before_edge", 64'(bus.pcis_awready), 64'd0);
    tick();
    check("awready_after_edge", 64'(bus.pcis_awready), 64'd1);

    // 4-beat burst at 0x1000 with latency checks.
    bus.pcis_bready = 1'b1;
    q_b.push_back(mk_b(16'h0011, RESP_OKAY));
    aw_send(16'h0011, 64'h1000, 8'd3);
    @(negedge clk);
    check("lat_req_wr_n1", 64'(bus.pcis_req_wr), 64'd0);
    check("busy_queued", 64'(busy), 64'd1);
    @(negedge clk);
    check("lat_req_wr_n2", 64'(bus.pcis_req_wr), 64'd1);
    tick();
    w_beats(64'h1000, 4, 1'b1);
    @(negedge clk);
    check("lat_bvalid_m1", 64'(bus.pcis_bvalid), 64'd0);
    check("req_wr_drop", 64'(bus.pcis_req_wr), 64'd0);
    @(negedge clk);
    check("lat_bvalid_m2", 64'(bus.pcis_bvalid), 64'd1);
    tick();
    drain();

    // Early wlast: len 3, wlast on 2nd beat -> single len_error pulse.
    q_b.push_back(mk_b(16'h0022, RESP_SLVERR));
    aw_send(16'h0022, 64'h2000, 8'd3);
    w_beats(64'h2000, 2, 1'b1);
    @(negedge clk);
    check("len_err_pulse", 64'(len_error), 64'd1);
    @(negedge clk);
    check("len_err_clear", 64'(len_error), 64'd0);
    len_err_exp += 1;
    tick();
    drain();

    // Overlong burst: len 1, three beats -> errors on beats 2 and 3.
    q_b.push_back(mk_b(16'h0033, RESP_SLVERR));
    aw_send(16'h0033, 64'h3000, 8'd1);
    w_beats(64'h3000, 3, 1'b1);
    len_err_exp += 2;
    drain();

    // ooo_error during DATA.
    q_b.push_back(mk_b(16'h0044, RESP_SLVERR));
    aw_send(16'h0044, 64'h4000, 8'd1);
    wait_req_wr();
    ooo_error = 1'b1;
    tick();
    ooo_error = 1'b0;
    w_beats(64'h4000, 2, 1'b1);
    drain();

    // unalin_error in the DRAIN cycle.
    q_b.push_back(mk_b(16'h0045, RESP_SLVERR));
    aw_send(16'h0045, 64'h4400, 8'd0);
    w_beats(64'h4400, 1, 1'b1);
    unalin_error = 1'b1;
    tick();
    unalin_error = 1'b0;
    drain();

    // unalin_error while IDLE must not taint the next burst.
    q_b.push_back(mk_b(16'h0046, RESP_OKAY));
    aw_send(16'h0046, 64'h4800, 8'd0);
    unalin_error = 1'b1;
    tick();
    unalin_error = 1'b0;
    w_beats(64'h4800, 1, 1'b1);
    drain();

    // Address wraps at 64 bits.
    q_b.push_back(mk_b(16'h0047, RESP_OKAY));
    aw_send(16'h0047, 64'hFFFF_FFFF_FFFF_FFC0, 8'd1);
    w_beats(64'hFFFF_FFFF_FFFF_FFC0, 2, 1'b1);
    drain();

    // Five back-to-back AWs with bready low: queue fills behind a stalled B.
    bus.pcis_bready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          q_b.push_back(mk_b(16'h0051 + 16'(i), RESP_OKAY));
          aw_send(16'h0051 + 16'(i), 64'h5000 + 64'(i) * 64'h100, 8'd0);
        end
      end
      begin
        w_beats(64'h5000, 1, 1'b1);
      end
    join
    repeat (3) tick();
    @(negedge clk);
    check("full_awready", 64'(bus.pcis_awready), 64'd0);
    check("stall_bvalid", 64'(bus.pcis_bvalid), 64'd1);
    check("stall_bid", 64'(bus.pcis_bid), 64'h0051);
    tick();
    repeat (2) tick();
    check("stall_bvalid_hold", 64'(bus.pcis_bvalid), 64'd1);
    check("stall_bid_hold", 64'(bus.pcis_bid), 64'h0051);
    check("stall_bresp_hold", 64'(bus.pcis_bresp), 64'(RESP_OKAY));
    bus.pcis_bready = 1'b1;
    begin
      int n = 0;
      while (!bus.pcis_awready && n < 10) begin
        tick();
        n++;
      end
    end
    check("awready_return", 64'(bus.pcis_awready), 64'd1);
    for (int i = 1; i < 5; i++) begin
      w_beats(64'h5000 + 64'(i) * 64'h100, 1, 1'b1);
    end
    drain();

    // Reset mid-DATA after two beats drops the burst without a response.
    aw_send(16'h0066, 64'h6000, 8'd3);
    w_beats(64'h6000, 2, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_awready_pre", 64'(bus.pcis_awready), 64'd0);
    tick();
    check("midrst_awready_post", 64'(bus.pcis_awready), 64'd1);
    q_b.push_back(mk_b(16'h0077, RESP_OKAY));
    aw_send(16'h0077, 64'h7000, 8'd1);
    w_beats(64'h7000, 2, 1'b1);
    drain();

    repeat (3) tick();
    check("addr_q_empty", 64'(q_addr.size()), 64'd0);
    check("len_err_count", 64'(len_err_seen), 64'(len_err_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
